seven_segment_decoder: RTL and testbench
========================================

SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

Interface
REQ-001: SETTLE_CYCLES, default 4; number of consecutive cycles an (anode, cathode) pair must be stable before its digit is captured; legal range 1..65535.
REQ-002: clk_in  input  1  system clock; all logic on posedge.
REQ-003: rst_in  input  1  synchronous, active-high reset.
REQ-004: cat_in  input  7  active-low segment cathodes {g,f,e,d,c,b,a}, bit 0 = a.
REQ-005: an_in  input  8  active-low digit anodes; bit k low selects digit k, which carries nibble k (bits 4k+3:4k).
REQ-006: val_out  output  32  last complete decoded frame.
REQ-007: valid_out  output  1  one-cycle pulse when val_out is loaded with a new frame.
REQ-008: digit_mask_out  output  8  digits captured in the current, incomplete frame.
REQ-009: err_out  output  1  sticky error flag.

Function
REQ-010: The block SHALL register an_in and cat_in once before use; all stability checks SHALL use the registered copies.
REQ-011: Decoding SHALL invert cat to active-high and map patterns as follows: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (hex). Any other pattern is invalid.
REQ-012: The FSM SHALL have three states: IDLE, SETTLE and HELD.
REQ-013: IDLE -> SETTLE when the registered anode is exactly one-hot (active-low); the stability counter SHALL clear.
REQ-014: In SETTLE, the counter SHALL increment each cycle the registered (an, cat) pair equals the previous cycle's pair; any change SHALL clear the counter and remain in SETTLE when still one-hot, or go to IDLE otherwise.
REQ-015: Capture: the pair has been present for SETTLE_CYCLES consecutive cycles and the pattern is valid. On that edge the nibble SHALL be written to the shadow register, the mask bit set, and the FSM SHALL go to HELD.
REQ-016: An invalid pattern reaching SETTLE_CYCLES SHALL NOT be captured; the FSM SHALL go to HELD and the error event of REQ-024 SHALL fire.
REQ-017: HELD -> SETTLE on any change of the registered pair while the anode is still one-hot; otherwise HELD -> IDLE. A digit SHALL be captured at most once per anode dwell.
REQ-018: Recapturing an already-masked digit SHALL overwrite its shadow nibble; the mask is unchanged.
REQ-019: When a capture completes the mask (8'hFF), the same edge SHALL load val_out with the full shadow value including the new nibble and clear the mask. valid_out SHALL be high for exactly the following cycle.
REQ-020: All anodes high (blank or en off) for SETTLE_CYCLES consecutive cycles SHALL clear the mask and shadow (frame abort). val_out SHALL be unchanged.
REQ-021: Multi-hot anode SHALL be treated as no valid digit (IDLE) and fires the error event.
REQ-022: The counter SHALL saturate at SETTLE_CYCLES and never wrap.

Reset
REQ-023: On rst_in: FSM=IDLE, counter=0, shadow=0, val_out=32'h0, valid_out=0, digit_mask_out=8'h00, err_out=0, input registers=all ones. Reset mid-frame discards the partial frame.

Configuration
REQ-024: SEVSEG_DEC_ERR_EN defined: err_out SHALL set on an invalid-pattern or multi-hot error event and clear only on rst_in. Undefined: err_out SHALL be tied 0, no error logic is built, and the decode behaviour is otherwise identical.

Verification
REQ-025: Drive from seven_segment_controller (COUNT_TO=10, en_in=1, val_in=32'hDEADBEEF) -> val_out=32'hDEADBEEF. valid_out pulses once per 8 digit periods. err_out=0.
REQ-026: Hold digit 3 one-hot with a valid pattern toggled every 2 cycles, SETTLE_CYCLES=4 -> no capture, and bit 3 of digit_mask_out stays 0.
REQ-027: Capture digits 0-4 (val 0x12345), then blank all anodes for 4 cycles -> digit_mask_out=8'h00 and val_out unchanged. The next full frame of 0x0000_0007 -> val_out=32'h00000007.
REQ-028: an_in=8'b1111_1100, then cat_in=~7'h00 on a one-hot digit -> no capture. err_out=1 with SEVSEG_DEC_ERR_EN and 0 without.
REQ-029: Assert rst_in after 6 of 8 digits -> all outputs at reset values on the next cycle. A subsequent full frame of 32'hCAFEF00D decodes correctly.

Source files
------------

// File: rtl/seven_segment_decoder.sv
// Recovers a 32-bit value from a multiplexed 8-digit seven-segment drive (anodes + cathodes).
// Optional sticky error flag enabled by defining SEVSEG_DEC_ERR_EN.
module seven_segment_decoder #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [6:0]  cat_in,
   input  logic [7:0]  an_in,
   output logic [31:0] val_out,
   output logic        valid_out,
   output logic [7:0]  digit_mask_out,
   output logic        err_out,
   output logic [1:0]  state_out
);

   // valid_out is a one-cycle strobe with no backpressure; val_out holds until the next frame.
   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HELD = 2'd2} state_t;

   localparam logic [15:0] SETTLE_MAX = 16'(SETTLE_CYCLES);

   state_t      state, state_d;
   logic [15:0] cnt, cnt_d, blank_cnt;
   logic [7:0]  an_q, an_p, an_hot;
   logic [6:0]  cat_q, cat_p;
   logic        one_hot, multi_hot, blank, same, settle_done, abort, capture;
   logic [2:0]  dig_idx;
   logic [3:0]  nib;
   logic        pat_ok;
   logic [31:0] shadow, shadow_upd;
   logic [7:0]  mask_upd;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         an_q  <= 8'hFF;
         cat_q <= 7'h7F;
         an_p  <= 8'hFF;
         cat_p <= 7'h7F;
      end else begin
         an_q  <= an_in;
         cat_q <= cat_in;
         an_p  <= an_q;
         cat_p <= cat_q;
      end
   end

   assign an_hot      = ~an_q;
   assign one_hot     = (an_hot != 8'd0) && ((an_hot & (an_hot - 8'd1)) == 8'd0);
   assign multi_hot   = (an_hot != 8'd0) && !one_hot;
   assign blank       = (an_q == 8'hFF);
   assign same        = (an_q == an_p) && (cat_q == cat_p);
   // cnt counts equal comparisons, so the pair has been present for cnt+2 cycles after this one.
   assign settle_done = same && (({1'b0, cnt} + 17'd2) >= {1'b0, SETTLE_MAX});
   assign abort       = blank && (({1'b0, blank_cnt} + 17'd1) >= {1'b0, SETTLE_MAX});
   assign state_out   = state;

   always_comb begin
      dig_idx = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (an_hot[k]) dig_idx = 3'(k);
      end
   end

   always_comb begin
      pat_ok = 1'b1;
      nib    = 4'h0;
      case (~cat_q)
         7'h3F: nib = 4'h0;
         7'h06: nib = 4'h1;
         7'h5B: nib = 4'h2;
         7'h4F: nib = 4'h3;
         7'h66: nib = 4'h4;
         7'h6D: nib = 4'h5;
         7'h7D: nib = 4'h6;
         7'h07: nib = 4'h7;
         7'h7F: nib = 4'h8;
         7'h6F: nib = 4'h9;
         7'h77: nib = 4'hA;
         7'h7C: nib = 4'hB;
         7'h39: nib = 4'hC;
         7'h5E: nib = 4'hD;
         7'h79: nib = 4'hE;
         7'h71: nib = 4'hF;
         default: pat_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      capture = 1'b0;
      if (multi_hot) begin
         state_d = IDLE;
         cnt_d   = 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (one_hot) begin
                  state_d = SETTLE;
                  cnt_d   = 16'd0;
               end
            end
            SETTLE: begin
               if (!one_hot) begin
                  state_d = IDLE;
                  cnt_d   = 16'd0;
               end else if (!same) begin
                  cnt_d = 16'd0;
               end else if (settle_done) begin
                  state_d = HELD;
                  capture = pat_ok;
                  cnt_d   = SETTLE_MAX;
               end else if (cnt < SETTLE_MAX) begin
                  cnt_d = cnt + 16'd1;
               end
            end
            HELD: begin
               // Staying on the same pair never re-arms, so each dwell captures at most once.
               if (!one_hot) begin
                  state_d = IDLE;
               end else if (!same) begin
                  state_d = SETTLE;
                  cnt_d   = 16'd0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
         cnt   <= 16'd0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   always_comb begin
      shadow_upd = shadow;
      shadow_upd[{dig_idx, 2'b00} +: 4] = nib;
      mask_upd = digit_mask_out | (8'd1 << dig_idx);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         blank_cnt      <= 16'd0;
         shadow         <= 32'h0;
         digit_mask_out <= 8'h00;
         val_out        <= 32'h0;
         valid_out      <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (!blank) blank_cnt <= 16'd0;
         else if (blank_cnt < SETTLE_MAX) blank_cnt <= blank_cnt + 16'd1;
         if (capture) begin
            if (mask_upd == 8'hFF) begin
               val_out        <= shadow_upd;
               valid_out      <= 1'b1;
               digit_mask_out <= 8'h00;
               shadow         <= 32'h0;
            end else begin
               shadow         <= shadow_upd;
               digit_mask_out <= mask_upd;
            end
         end else if (abort) begin
            digit_mask_out <= 8'h00;
            shadow         <= 32'h0;
         end
      end
   end

`ifdef SEVSEG_DEC_ERR_EN
   logic err_evt, err_q;
   assign err_evt = multi_hot || ((state == SETTLE) && one_hot && settle_done && !pat_ok);
   always_ff @(posedge clk_in) begin
      if (rst_in) err_q <= 1'b0;
      else if (err_evt) err_q <= 1'b1;
   end
   assign err_out = err_q;
`else
   assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder: table of full frames plus hand-written
// sequences for settle timing, frame abort, recapture, reset and error cases.
module tb_seven_segment_decoder;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [6:0]  cat_in = 7'h7F;
   logic [7:0]  an_in  = 8'hFF;
   logic [31:0] val_out;
   logic        valid_out;
   logic [7:0]  digit_mask_out;
   logic        err_out;
   logic [1:0]  state_out;

`ifdef SEVSEG_DEC_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   seven_segment_decoder #(.SETTLE_CYCLES(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .cat_in(cat_in), .an_in(an_in),
      .val_out(val_out), .valid_out(valid_out), .digit_mask_out(digit_mask_out),
      .err_out(err_out), .state_out(state_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [31:0] frame;
      int          dwell;
      logic [31:0] exp_val;
   } vec_t;

   vec_t       vecs[6];
   logic [6:0] seg_tab[16];
   int         n_vec = 0;
   int         n_err = 0;
   int         valid_cnt = 0;
   int         v0;

   always @(negedge clk_in) if (valid_out === 1'b1) valid_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_raw(input logic [7:0] an, input logic [6:0] cat, input int cyc);
      an_in  = an;
      cat_in = cat;
      repeat (cyc) @(negedge clk_in);
   endtask

   task automatic drive_digit(input int k, input logic [3:0] n, input int cyc);
      logic [7:0] sel;
      sel = 8'd1 << k;
      drive_raw(~sel, ~seg_tab[n], cyc);
   endtask

   task automatic frame(input logic [31:0] v, input int dwell, input int first, input int last);
      for (int k = first; k <= last; k++) drive_digit(k, v[4*k +: 4], dwell);
   endtask

   task automatic blank(input int cyc);
      drive_raw(8'hFF, 7'h7F, cyc);
   endtask

   task automatic pulse_reset();
      an_in  = 8'hFF;
      cat_in = 7'h7F;
      rst_in = 1'b1;
      @(negedge clk_in);
      check("rst val_out", val_out, 32'h0);
      check("rst valid_out", {31'd0, valid_out}, 32'd0);
      check("rst mask", {24'd0, digit_mask_out}, 32'd0);
      check("rst err_out", {31'd0, err_out}, 32'd0);
      check("rst state", {30'd0, state_out}, 32'd0);
      rst_in = 1'b0;
   endtask

   initial begin
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      vecs[0] = '{32'h01234567, 4, 32'h01234567};
      vecs[1] = '{32'h89ABCDEF, 4, 32'h89ABCDEF};
      vecs[2] = '{32'hFEDCBA98, 7, 32'hFEDCBA98};
      vecs[3] = '{32'h00000000, 4, 32'h00000000};
      vecs[4] = '{32'hFFFFFFFF, 5, 32'hFFFFFFFF};
      vecs[5] = '{32'h5A5AA5A5, 4, 32'h5A5AA5A5};

      @(negedge clk_in);
      pulse_reset();

      for (int i = 0; i < 6; i++) begin
         v0 = valid_cnt;
         frame(vecs[i].frame, vecs[i].dwell, 0, 7);
         blank(2);
         check($sformatf("vec%0d val_out", i), val_out, vecs[i].exp_val);
         check($sformatf("vec%0d valid pulses", i), 32'(valid_cnt - v0), 32'd1);
         check($sformatf("vec%0d mask", i), {24'd0, digit_mask_out}, 32'd0);
      end

      // Controller-like scan: dwell 10, three back-to-back frames.
      v0 = valid_cnt;
      for (int f = 0; f < 3; f++) frame(32'hDEADBEEF, 10, 0, 7);
      blank(2);
      check("scan val_out", val_out, 32'hDEADBEEF);
      check("scan valid pulses", 32'(valid_cnt - v0), 32'd3);
      check("scan err_out", {31'd0, err_out}, 32'd0);

      // Frame abort after five digits.
      frame(32'h00012345, 4, 0, 4);
      blank(1);
      check("partial mask", {24'd0, digit_mask_out}, 32'h1F);
      blank(4);
      check("abort mask", {24'd0, digit_mask_out}, 32'h00);
      check("abort val_out", val_out, 32'hDEADBEEF);
      frame(32'h00000007, 4, 0, 7);
      blank(2);
      check("post-abort val_out", val_out, 32'h00000007);

      // Blank gap one cycle short of abort keeps the partial frame.
      frame(32'h13579BDF, 4, 0, 2);
      blank(3);
      frame(32'h13579BDF, 4, 3, 7);
      blank(2);
      check("short blank val_out", val_out, 32'h13579BDF);

      // Digit 3 pattern toggling every 2 cycles never settles.
      for (int r = 0; r < 6; r++) begin
         drive_digit(3, 4'h5, 2);
         drive_digit(3, 4'h6, 2);
      end
      blank(1);
      check("toggle mask bit3", {31'd0, digit_mask_out[3]}, 32'd0);
      blank(4);

      // Dwell boundary: 3 cycles is too short, 4 cycles captures.
      drive_digit(0, 4'h9, 3);
      blank(2);
      check("dwell3 mask", {24'd0, digit_mask_out}, 32'h00);
      drive_digit(0, 4'h9, 4);
      blank(1);
      check("dwell4 mask", {24'd0, digit_mask_out}, 32'h01);
      blank(5);

      // Recapture on the same digit overwrites the nibble.
      drive_digit(0, 4'h1, 4);
      drive_digit(0, 4'h3, 4);
      drive_digit(1, 4'h9, 1);
      check("recapture mask", {24'd0, digit_mask_out}, 32'h01);
      drive_digit(1, 4'h9, 3);
      frame(32'hFEDCBA90, 4, 2, 7);
      blank(2);
      check("recapture val_out", val_out, 32'hFEDCBA93);

      // Reset mid-frame, then a clean frame.
      frame(32'h11111111, 4, 0, 5);
      pulse_reset();
      frame(32'hCAFEF00D, 4, 0, 7);
      blank(2);
      check("after reset val_out", val_out, 32'hCAFEF00D);

      // Multi-hot anodes.
      pulse_reset();
      drive_raw(8'b1111_1100, ~seg_tab[4'h2], 3);
      blank(1);
      check("multihot err_out", {31'd0, err_out}, {31'd0, EXP_ERR});
      check("multihot mask", {24'd0, digit_mask_out}, 32'h00);

      // Invalid (all segments off) pattern on a one-hot digit.
      pulse_reset();
      drive_raw(8'b1111_1101, 7'h7F, 6);
      blank(1);
      check("invalid mask", {24'd0, digit_mask_out}, 32'h00);
      check("invalid err_out", {31'd0, err_out}, {31'd0, EXP_ERR});
      drive_digit(1, 4'h4, 4);
      blank(1);
      check("valid after invalid mask", {24'd0, digit_mask_out}, 32'h02);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
